mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 17, gives the byte-RAM address width (128 KB).
REQ-002 Parameter TXF_LOG, default 3, gives log2 of the TX FIFO depth (8 entries).
REQ-003 Port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port rdy_in, input, 1 bit: high when the system runs; low freezes the cycle counter only.
REQ-006 Port cpu_a, input, 32 bits: byte address from the CPU.
REQ-007 Port cpu_wr, input, 1 bit: 1 selects write and 0 selects read.
REQ-008 Port cpu_dout, input, 8 bits: write data from the CPU.
REQ-009 Port cpu_din, output, 8 bits: registered read data, valid one cycle after the address.
REQ-010 Port io_buffer_full, output, 1 bit: high when the TX FIFO cannot safely accept a write.
REQ-011 Port rx_data, input, 8 bits: UART receive byte.
REQ-012 Port rx_valid, input, 1 bit: rx_data is available.
REQ-013 Port rx_pop, output, 1 bit: one-cycle pulse that consumes rx_data.
REQ-014 Port tx_data, output, 8 bits: head byte of the TX FIFO.
REQ-015 Port tx_valid, output, 1 bit: the TX FIFO is non-empty.
REQ-016 Port tx_ready, input, 1 bit: the UART accepts tx_data on a cycle where tx_valid && tx_ready.
REQ-017 Port program_stop, output, 1 bit: sticky flag, set on a write to 0x30004.
REQ-018 Port tx_overflow, output, 1 bit: sticky flag, set when a TX byte is dropped.

Function
REQ-019 IO select SHALL be cpu_a[17:16]==2'b11, RAM select SHALL be cpu_a[17]==0, and every other address SHALL be unmapped.
REQ-020 One access SHALL be serviced every cycle, independent of rdy_in.
REQ-021 A RAM write SHALL store cpu_dout at cpu_a[RAM_ADDR_WIDTH-1:0] in that cycle.
REQ-022 A RAM read SHALL return its byte on cpu_din at the next rising edge (1-cycle latency).
REQ-023 An unmapped read SHALL return 0x00 and an unmapped write SHALL be ignored.
REQ-024 A read of 0x30000 SHALL return rx_data next cycle with rx_pop asserted that cycle when rx_valid=1, and SHALL return 0x00 with no pop when rx_valid=0.
REQ-025 A 32-bit cycle counter SHALL increment on every clock with rdy_in=1 and wrap 0xFFFFFFFF->0.
REQ-026 A read of 0x30004 SHALL latch the counter into a snapshot and return snapshot byte 0, computed from the pre-increment counter value.
REQ-027 Reads of 0x30005, 0x30006 and 0x30007 SHALL return snapshot bytes 1, 2 and 3 without relatching.
REQ-028 A write of a nonzero byte to 0x30000 SHALL push that byte into the TX FIFO, and a write of 0x00 SHALL be ignored.
REQ-029 A write to 0x30004 SHALL set program_stop and push 0x00 into the TX FIFO.
REQ-030 A write to any other IO address SHALL be ignored.
REQ-031 The TX FIFO SHALL be a circular buffer with TXF_LOG-bit pointers that wrap, plus a count of TXF_LOG+1 bits.
REQ-032 On a push and a pop in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-033 When count equals the depth, a push SHALL be dropped unless a pop occurs in the same cycle, and a dropped push SHALL set tx_overflow.
REQ-034 io_buffer_full SHALL be registered and equal 1 when, after the current push and pop, count >= depth-1, leaving one slot of margin for the registration delay.
REQ-035 tx_valid SHALL equal (count!=0), and tx_data SHALL be the head entry, combinational from registered state.
REQ-036 program_stop and tx_overflow SHALL stay set until reset.

Reset
REQ-037 Asserting rst_n_in low SHALL immediately clear cpu_din, rx_pop, io_buffer_full, program_stop, tx_overflow, the counter, the snapshot, the TX FIFO pointers and the count.
REQ-038 During reset, tx_valid SHALL be 0.
REQ-039 RAM contents SHALL NOT be reset.
REQ-040 Reset asserted mid-drain SHALL discard all queued TX bytes.
REQ-041 After release of reset, the first access SHALL be serviced on the first rising edge.

Verification
REQ-042 Write 0xA5 to 0x00010, then read 0x00010 -> cpu_din=0xA5 exactly one cycle after the read address; a read of 0x20000 -> 0x00.
REQ-043 Hold tx_ready=0 and write 'H','i',0x00 and then 7 more nonzero bytes to 0x30000 -> 0x00 not queued, io_buffer_full=1 once count reaches 7, 9th nonzero byte dropped with tx_overflow=1; raise tx_ready -> 8 bytes drained in order, with tx_valid falling after the last.
REQ-044 With count=8 and tx_ready=1, push in the same cycle -> byte accepted, count stays 8, tx_overflow stays 0.
REQ-045 rdy_in=1 for 100 cycles after reset, then read 0x30004 through 0x30007 -> bytes assemble to the latched value 100 (+/- bench offset, fixed), and bytes 1-3 match the snapshot even though the counter advanced.
REQ-046 rx_valid=1 with rx_data=0x41, read 0x30000 -> cpu_din=0x41 and rx_pop pulses exactly once; with rx_valid=0 -> 0x00 and no pop.
REQ-047 Write to 0x30004 with 3 bytes queued, then pull rst_n_in low mid-drain -> program_stop=1 and 0x00 queued last before reset; all outputs reach reset values asynchronously and RAM data is retained.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART RX/TX handshake bundle for mem_io_responder.
// master = CPU/UART side, slave = the responder.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output cpu_a, cpu_wr, cpu_dout,
        output rx_data, rx_valid, tx_ready,
        input  cpu_din, io_buffer_full,
        input  rx_pop, tx_data, tx_valid
    );

    modport slave (
        input  cpu_a, cpu_wr, cpu_dout,
        input  rx_data, rx_valid, tx_ready,
        output cpu_din, io_buffer_full,
        output rx_pop, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped UART RX, TX FIFO and cycle counter.
// One CPU access per cycle; read data returns one cycle later.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TXF_LOG        = 3
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    mem_io_responder_if.slave  bus,
    output logic               program_stop,
    output logic               tx_overflow
);

    localparam int DEPTH = 1 << TXF_LOG;
    localparam int CW    = TXF_LOG + 1;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_IO
    } src_e;

    logic [7:0] ram [2**RAM_ADDR_WIDTH];
    logic [7:0] ram_q;
    logic [7:0] txf [DEPTH];

    src_e         src_q, src_d;
    logic [7:0]   io_q, io_d;
    logic         rx_pop_q, rx_pop_d;
    logic [31:0]  cnt_q;
    logic [31:0]  snap_q, snap_d;
    logic [TXF_LOG-1:0] wptr_q, rptr_q;
    logic [CW-1:0] txc_q, txc_d;
    logic         full_q, full_d;
    logic         stop_q, ovf_q;

    logic        rd, wr, io_sel, ram_sel;
    logic [15:0] io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic        tx_push, tx_pop, tx_full, accept, drop, stop_set;
    logic [7:0]  tx_byte;
    logic        unused_ok;

    assign unused_ok = ^bus.cpu_a[31:18];

    assign wr      = bus.cpu_wr;
    assign rd      = !bus.cpu_wr;
    assign io_sel  = bus.cpu_a[17:16] == 2'b11;
    assign ram_sel = !bus.cpu_a[17];
    assign io_off  = bus.cpu_a[15:0];
    assign ram_idx = bus.cpu_a[RAM_ADDR_WIDTH-1:0];

    // Read side: select and IO byte are registered, RAM data kept separately
    always_comb begin
        src_d    = SRC_ZERO;
        io_d     = 8'h00;
        rx_pop_d = 1'b0;
        snap_d   = snap_q;
        if (rd && ram_sel) begin
            src_d = SRC_RAM;
        end else if (rd && io_sel) begin
            src_d = SRC_IO;
            unique case (1'b1)
                io_off == 16'h0000: begin
                    if (bus.rx_valid) begin
                        io_d     = bus.rx_data;
                        rx_pop_d = 1'b1;
                    end
                end
                io_off == 16'h0004: begin
                    snap_d = cnt_q;
                    io_d   = cnt_q[7:0];
                end
                io_off == 16'h0005: io_d = snap_q[15:8];
                io_off == 16'h0006: io_d = snap_q[23:16];
                io_off == 16'h0007: io_d = snap_q[31:24];
                default:            io_d = 8'h00;
            endcase
        end
    end

    assign stop_set = wr && io_sel && io_off == 16'h0004;
    assign tx_push  = stop_set ||
                      (wr && io_sel && io_off == 16'h0000 &&
                       bus.cpu_dout != 8'h00);
    assign tx_byte  = stop_set ? 8'h00 : bus.cpu_dout;
    assign tx_pop   = (txc_q != '0) && bus.tx_ready;
    assign tx_full  = txc_q == CW'(DEPTH);
    assign accept   = tx_push && (!tx_full || tx_pop);
    assign drop     = tx_push && tx_full && !tx_pop;

    always_comb begin
        txc_d = txc_q;
        if (accept && !tx_pop) begin
            txc_d = txc_q + 1'b1;
        end else if (!accept && tx_pop) begin
            txc_d = txc_q - 1'b1;
        end
        // One slot of margin covers the cycle the CPU needs to see it
        full_d = txc_d >= CW'(DEPTH - 1);
    end

    always_ff @(posedge clk_in) begin
        if (wr && ram_sel) begin
            ram[ram_idx] <= bus.cpu_dout;
        end
        ram_q <= ram[ram_idx];
        if (accept) begin
            txf[wptr_q] <= tx_byte;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_q    <= SRC_ZERO;
            io_q     <= 8'h00;
            rx_pop_q <= 1'b0;
            cnt_q    <= '0;
            snap_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            txc_q    <= '0;
            full_q   <= 1'b0;
            stop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            src_q    <= src_d;
            io_q     <= io_d;
            rx_pop_q <= rx_pop_d;
            snap_q   <= snap_d;
            txc_q    <= txc_d;
            full_q   <= full_d;
            if (rdy_in) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (accept) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (tx_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (stop_set) begin
                stop_q <= 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        unique case (src_q)
            SRC_RAM: bus.cpu_din = ram_q;
            SRC_IO:  bus.cpu_din = io_q;
            default: bus.cpu_din = 8'h00;
        endcase
    end

    assign bus.rx_pop         = rx_pop_q;
    assign bus.io_buffer_full = full_q;
    assign bus.tx_valid       = txc_q != '0;
    assign bus.tx_data        = txf[rptr_q];
    assign program_stop       = stop_q;
    assign tx_overflow        = ovf_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed scenarios plus random traffic for mem_io_responder,
// checked against a queue/array reference model.
module tb_mem_io_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rdy = 1'b0;
    logic program_stop;
    logic tx_overflow;

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .rdy_in       (rdy),
        .bus          (bus),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]   mram [int];
    byte unsigned mq [$];
    logic [31:0]  mcnt;
    logic [31:0]  msnap;
    bit           mstop;
    bit           movf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_din", bus.cpu_din, 0);
        chk("rst_pop", bus.rx_pop, 0);
        chk("rst_full", bus.io_buffer_full, 0);
        chk("rst_stop", program_stop, 0);
        chk("rst_ovf", tx_overflow, 0);
        chk("rst_txv", bus.tx_valid, 0);
        mq.delete();
        mcnt  = 0;
        msnap = 0;
        mstop = 0;
        movf  = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input string tag, input logic [31:0] a,
                        input bit w, input logic [7:0] d,
                        input bit rd_y = 1'b1, input bit rxv = 1'b0,
                        input logic [7:0] rxd = 8'h00,
                        input bit txr = 1'b0);
        bit         chk_din;
        logic [7:0] exp_din;
        bit         exp_pop;
        chk_din = 0;
        exp_din = 8'h00;
        exp_pop = 0;
        bus.cpu_a    = a;
        bus.cpu_wr   = w;
        bus.cpu_dout = d;
        bus.rx_valid = rxv;
        bus.rx_data  = rxd;
        bus.tx_ready = txr;
        rdy          = rd_y;
        if (!w) begin
            if (!a[17]) begin
                if (mram.exists(int'(a[16:0]))) begin
                    chk_din = 1;
                    exp_din = mram[int'(a[16:0])];
                end
            end else if (!a[16]) begin
                chk_din = 1;
            end else begin
                chk_din = 1;
                case (a[15:0])
                    16'h0000: if (rxv) begin
                        exp_din = rxd;
                        exp_pop = 1;
                    end
                    16'h0004: begin
                        msnap   = mcnt;
                        exp_din = mcnt[7:0];
                    end
                    16'h0005: exp_din = msnap[15:8];
                    16'h0006: exp_din = msnap[23:16];
                    16'h0007: exp_din = msnap[31:24];
                    default:  exp_din = 8'h00;
                endcase
            end
        end else if (!a[17]) begin
            mram[int'(a[16:0])] = d;
        end
        if (mq.size() != 0 && txr) begin
            void'(mq.pop_front());
        end
        if (w && a[17:16] == 2'b11 &&
            ((a[15:0] == 16'h0 && d != 8'h0) || a[15:0] == 16'h4)) begin
            if (a[15:0] == 16'h4) mstop = 1;
            if (mq.size() < 8) begin
                mq.push_back((a[15:0] == 16'h4) ? 8'h00 : d);
            end else begin
                movf = 1;
            end
        end
        if (rd_y) mcnt = mcnt + 1;
        @(posedge clk);
        #1;
        if (chk_din) chk({tag, ".din"}, bus.cpu_din, exp_din);
        chk({tag, ".pop"}, bus.rx_pop, exp_pop);
        chk({tag, ".txv"}, bus.tx_valid, mq.size() != 0);
        if (mq.size() != 0) chk({tag, ".txd"}, bus.tx_data, mq[0]);
        chk({tag, ".full"}, bus.io_buffer_full, mq.size() >= 7);
        chk({tag, ".stop"}, program_stop, mstop);
        chk({tag, ".ovf"}, tx_overflow, movf);
        @(negedge clk);
    endtask

    task automatic idle(input bit txr);
        step("idle", 32'h20000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, txr);
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        logic [7:0]  d;
        int          k;
        bus.cpu_a    = 32'h20000;
        bus.cpu_wr   = 1'b0;
        bus.cpu_dout = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        mcnt = 0; msnap = 0; mstop = 0; movf = 0;
        @(negedge clk);
        do_reset();

        step("w10", 32'h10, 1'b1, 8'hA5);
        step("r10", 32'h10, 1'b0, 8'h00);
        chk("ram_a5", bus.cpu_din, 8'hA5);
        step("unm", 32'h20000, 1'b0, 8'h00);
        chk("unm_zero", bus.cpu_din, 8'h00);

        step("rx", 32'h30000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41);
        chk("rx41", bus.cpu_din, 8'h41);
        chk("rxpop1", bus.rx_pop, 1);
        step("rxi", 32'h20000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41);
        step("rxe", 32'h30000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41);
        chk("rxempty", bus.cpu_din, 8'h00);

        step("tH", 32'h30000, 1'b1, 8'h48);
        step("ti", 32'h30000, 1'b1, 8'h69);
        step("t0", 32'h30000, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step("tb", 32'h30000, 1'b1, 8'h30 + 8'(i));
            if (i == 4) chk("full_at7", bus.io_buffer_full, 1);
        end
        chk("ovf_9th", tx_overflow, 1);
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("drained", bus.tx_valid, 0);

        do_reset();
        for (int i = 0; i < 8; i++) step("f8", 32'h30000, 1'b1, 8'h50 + 8'(i));
        step("f8pp", 32'h30000, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("pp_noovf", tx_overflow, 0);
        for (int i = 0; i < 9; i++) idle(1'b1);
        chk("pp_drain", bus.tx_valid, 0);

        do_reset();
        for (int i = 0; i < 100; i++) idle(1'b0);
        step("c4", 32'h30004, 1'b0, 8'h00);
        chk("cnt100", bus.cpu_din, 8'd100);
        step("c5", 32'h30005, 1'b0, 8'h00);
        step("c6", 32'h30006, 1'b0, 8'h00);
        step("c7", 32'h30007, 1'b0, 8'h00);

        step("w40", 32'h40, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) step("q3", 32'h30000, 1'b1, 8'h61 + 8'(i));
        step("wstop", 32'h30004, 1'b1, 8'h12);
        chk("stop_set", program_stop, 1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        step("r40", 32'h40, 1'b0, 8'h00);
        chk("ram_kept", bus.cpu_din, 8'h5A);

        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 8);
            w = 1'b0;
            d = 8'($urandom);
            case (k)
                0, 1: begin a = 32'($urandom_range(0, 31)); w = 1'b1; end
                2, 3: a = 32'($urandom_range(0, 31));
                4: begin
                    a = 32'h20000 | 32'($urandom_range(0, 65535));
                    w = 1'($urandom);
                end
                5: a = 32'h30000;
                6: a = 32'h30004 + 32'($urandom_range(0, 4));
                7: begin
                    a = 32'h30000;
                    w = 1'b1;
                    if ($urandom_range(0, 3) == 0) d = 8'h00;
                end
                default: begin
                    a = 32'h30000 + 32'($urandom_range(1, 8));
                    w = 1'b1;
                end
            endcase
            step("rnd", a, w, d, $urandom_range(0, 3) != 0,
                 1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
